tile_scanner: RTL

- Upstream neighbour of the VGA colour mapper.
- Holds the 16x16 playfield tile-state map, which game logic writes.
- Tracks the VGA raster (DrawX/DrawY) with incremental counters instead of dividers.
- Per pixel it emits the tile state, the in-tile background-ROM read address and an in-playfield flag, pipeline-aligned for the colour mapper.

---
 rtl/tile_pkg.sv | 28 ++
 rtl/tile_map_ram.sv | 49 ++++
 rtl/tile_scanner.sv | 134 +++++++++++++
 3 files changed

// File: rtl/tile_pkg.sv
// Shared constants and types for the playfield tile scanner.
// Geometry: 16x16 square tiles of 30 px, playfield starting at column 80.
// Types: tile_state_t (per-tile state), tile_idx_t ({tile_y, tile_x}),
// tile_kind_e (named tile kinds stored in the map).
package tile_pkg;

    localparam int FIELD_X0 = 80;
    localparam int TILE_W   = 30;
    localparam int TILES_X  = 16;
    localparam int TILES_Y  = 16;
    localparam int STATE_W  = 4;
    localparam int H_TOTAL  = 800;
    localparam int V_ACTIVE = 480;

    typedef logic [STATE_W-1:0] tile_state_t;
    typedef logic [7:0]         tile_idx_t;

    typedef enum logic [STATE_W-1:0] {
        EMPTY   = 4'd0,
        WALL    = 4'd1,
        BRICK   = 4'd2,
        BOMB    = 4'd3,
        FLAME   = 4'd4,
        PLAYER1 = 4'd5,
        PLAYER2 = 4'd6
    } tile_kind_e;

endpackage

// File: rtl/tile_map_ram.sv
// 256-entry tile-state map, cleared by asynchronous reset.
// Ports:
//   clk, rst_n            clock, async active-low reset (clears every entry)
//   we, waddr, wdata      game-logic write port, sampled every clock
//   scan_addr, scan_data  combinational read for the scanner (scanner registers it)
//   rd_addr, rd_data      registered readback, 1-clock latency (TILE_RDBK_EN only)
// A write and a read of the same entry in one cycle returns the old contents.
module tile_map_ram
    import tile_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [7:0]         waddr,
    input  logic [STATE_W-1:0] wdata,
    input  logic [7:0]         scan_addr,
    output logic [STATE_W-1:0] scan_data
`ifdef TILE_RDBK_EN
    ,
    input  logic [7:0]         rd_addr,
    output logic [STATE_W-1:0] rd_data
`endif
);

    logic [STATE_W-1:0] mem [256];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 256; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign scan_data = mem[scan_addr];

`ifdef TILE_RDBK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end
`endif

endmodule

// File: rtl/tile_scanner.sv
// Tracks the VGA raster with incremental tile counters and emits, per pixel,
// the tile state, in-tile background-ROM address and playfield flag, two
// pixel_en strobes after DrawX/DrawY.
// Ports:
//   Clk, Reset_n          clock, async active-low reset
//   pixel_en              pipeline advance strobe
//   DrawX, DrawY          raster position
//   map_we/waddr/wdata    tile-map write (independent of pixel_en)
//   map_raddr/map_rdata   map readback, 1-clock latency (TILE_RDBK_EN only)
//   tile_state, rom_addr, in_field, draw_x_d, draw_y_d   aligned outputs
// Optional feature macro: TILE_RDBK_EN.
module tile_scanner
    import tile_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               pixel_en,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    input  logic               map_we,
    input  logic [7:0]         map_waddr,
    input  logic [STATE_W-1:0] map_wdata,
`ifdef TILE_RDBK_EN
    input  logic [7:0]         map_raddr,
    output logic [STATE_W-1:0] map_rdata,
`endif
    output logic [STATE_W-1:0] tile_state,
    output logic [9:0]         rom_addr,
    output logic               in_field,
    output logic [9:0]         draw_x_d,
    output logic [9:0]         draw_y_d
);

    localparam logic [9:0] X_START  = 10'(FIELD_X0);
    localparam logic [9:0] X_END    = 10'(FIELD_X0 + TILE_W * TILES_X);
    localparam logic [9:0] Y_END    = 10'(TILE_W * TILES_Y);
    localparam logic [4:0] OFF_MAX  = 5'(TILE_W - 1);
    localparam logic [3:0] TX_MAX   = 4'(TILES_X - 1);
    localparam logic [3:0] TY_MAX   = 4'(TILES_Y - 1);
    localparam logic [9:0] ROW_STEP = 10'(TILE_W);

    // stage 1
    logic [4:0]         x_off, y_off;
    logic [3:0]         tile_x, tile_y;
    logic [9:0]         row_base;
    logic               in_field_s1;
    logic [9:0]         dx_s1, dy_s1;

    logic               x_in, y_in;
    logic [STATE_W-1:0] scan_data;

    assign x_in = (DrawX >= X_START) && (DrawX < X_END);
    assign y_in = (DrawY < Y_END);

    // row_base carries y_off*TILE_W so rom_addr needs only an add, no multiply.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            x_off       <= '0;
            tile_x      <= '0;
            y_off       <= '0;
            tile_y      <= '0;
            row_base    <= '0;
            in_field_s1 <= 1'b0;
            dx_s1       <= '0;
            dy_s1       <= '0;
        end else if (pixel_en) begin
            if (DrawX == X_START) begin
                x_off  <= '0;
                tile_x <= '0;
            end else if (x_in) begin
                if (x_off == OFF_MAX) begin
                    x_off <= '0;
                    if (tile_x != TX_MAX) tile_x <= tile_x + 4'd1;
                end else begin
                    x_off <= x_off + 5'd1;
                end
            end

            if (DrawX == '0) begin
                if (DrawY == '0) begin
                    y_off    <= '0;
                    tile_y   <= '0;
                    row_base <= '0;
                end else if (y_in) begin
                    if (y_off == OFF_MAX) begin
                        y_off    <= '0;
                        row_base <= '0;
                        if (tile_y != TY_MAX) tile_y <= tile_y + 4'd1;
                    end else begin
                        y_off    <= y_off + 5'd1;
                        row_base <= row_base + ROW_STEP;
                    end
                end
            end

            in_field_s1 <= x_in && y_in;
            dx_s1       <= DrawX;
            dy_s1       <= DrawY;
        end
    end

    tile_map_ram u_map (
        .clk       (Clk),
        .rst_n     (Reset_n),
        .we        (map_we),
        .waddr     (map_waddr),
        .wdata     (map_wdata),
        .scan_addr ({tile_y, tile_x}),
        .scan_data (scan_data)
`ifdef TILE_RDBK_EN
        ,
        .rd_addr   (map_raddr),
        .rd_data   (map_rdata)
`endif
    );

    // stage 2: out-of-field pixels are forced to zero state/address
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            tile_state <= '0;
            rom_addr   <= '0;
            in_field   <= 1'b0;
            draw_x_d   <= '0;
            draw_y_d   <= '0;
        end else if (pixel_en) begin
            tile_state <= in_field_s1 ? scan_data : '0;
            rom_addr   <= in_field_s1 ? (row_base + 10'(x_off)) : '0;
            in_field   <= in_field_s1;
            draw_x_d   <= dx_s1;
            draw_y_d   <= dy_s1;
        end
    end

endmodule
